mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port 256x16 RAM (registered read, 1-cycle latency).
- Port 0 is the CPU memory interface; port 1 is a secondary master (DMA/loader).
- Accepts one access at a time, picks a winner round-robin, drives the RAM address/write/data, and returns read data with a done pulse.
- Accesses with address bit 8 set fall outside RAM and are completed with an error flag and no RAM activity.

Parameters:
- DATA_W, 16, data width of RAM words and requester data.
- ADDR_W, 9, requester address width; bit ADDR_W-1 set means outside RAM.
- RAM_AW, 8, RAM address width; equals ADDR_W-1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  synchronous active-low reset.
- req0, req1  in  1 each  request; held high with cmd/addr/wdata stable until that port's done.
- cmd0, cmd1  in  2 each  00 = MNONE, 01 = MREAD, 10 = MWRITE (11 treated as MNONE).
- addr0, addr1  in  ADDR_W each  word address.
- wdata0, wdata1  in  DATA_W each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse in the ISSUE cycle of that port's access.
- done0, done1  out  1 each  one-cycle completion pulse.
- rdata  out  DATA_W  read result; valid while a done is high after an MREAD.
- err  out  1  high with done when addr[ADDR_W-1] = 1.
- busy  out  1  high in every state except IDLE.
- ram_addr  out  RAM_AW  to RAM read and write address.
- ram_write  out  1  to RAM write enable.
- ram_din  out  DATA_W  to RAM write data.
- ram_dout  in  DATA_W  from RAM registered read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Registers: state, owner (1 bit), last (1 bit), cmd_q, addr_q, wdata_q, rdata.
- Reset (reset_n = 0 at a posedge):
  - State goes to IDLE.
  - gnt*, done*, err, busy, ram_write = 0; rdata = 0; ram_addr = 0; ram_din = 0.
  - last = 1, so port 0 wins the first tie.
  - Reset wins over every other event. Any in-flight access is dropped with no done.
  - ram_write is never high in the cycle after a reset edge.
- Valid request: reqN = 1 and cmdN is MREAD or MWRITE. reqN with MNONE/11 is ignored and never granted.
- IDLE:
  - No valid request: stay in IDLE.
  - One valid request: that port wins.
  - Both valid: winner = ~last.
  - On the winning edge: latch owner, cmd_q, addr_q, wdata_q; set last = owner; go to ISSUE.
- ISSUE (1 cycle):
  - gnt[owner] = 1; ram_addr = addr_q[RAM_AW-1:0]; ram_din = wdata_q.
  - ram_write = 1 only if cmd_q = MWRITE and addr_q[ADDR_W-1] = 0.
  - Next state: MREAD with in-range address -> WAIT; all other cases -> DONE.
- WAIT (1 cycle):
  - ram_addr is held; ram_write = 0.
  - ram_dout holds mem[addr_q]; it is captured into rdata at the closing edge. Go to DONE.
- DONE (1 cycle):
  - done[owner] = 1; err = addr_q[ADDR_W-1].
  - Out-of-range MREAD loads rdata = 0 on entry to DONE.
  - rdata holds its value until the next read completes.
  - Go to IDLE. The requester deasserts req or changes fields on the following edge.
- Latency, counted from the edge that samples req in IDLE:
  - In-range read: gnt in cycle 1, done plus data in cycle 3.
  - Write or out-of-range access: gnt in cycle 1, done in cycle 2.
- Throughput: one arbitration per pass through IDLE.
  - A port holding req continuously gets serviced again only after the other port, if the other port is requesting.
  - No starvation with both ports requesting: strict alternation.
- ram_write = 0 in every state except ISSUE.
- ram_addr and ram_din are registered-stable from ISSUE through DONE.
- Requests arriving while busy are not latched. They are evaluated in IDLE.
- Outputs gnt*, done*, err, busy are decoded from registered state only, with no combinational path from req*.

Test Plan:
- Reset for 2 cycles, then req0 = 1, cmd0 = MWRITE, addr0 = 9'h005, wdata0 = 16'hABCD.
  - Required: gnt0 in cycle 1, ram_write = 1 with ram_addr = 8'h05 in that same cycle, done0 in cycle 2, err = 0.
- After the write above, req0 MREAD addr0 = 9'h005.
  - Required: ram_write stays 0, done0 in cycle 3 with rdata = 16'hABCD.
- req0 and req1 both MREAD from reset, addr 9'h001 and 9'h002, preloaded 16'h1111 and 16'h2222.
  - Required: port 0 served first (done0, rdata = 16'h1111), then port 1 (done1, rdata = 16'h2222).
  - Then both write again: port 1 no longer wins; grants continue to alternate 0,1,0.
- req1 MWRITE addr1 = 9'h105, then MREAD addr1 = 9'h105.
  - Required: ram_write never asserted, err = 1 with each done1, read rdata = 16'h0000, mem[5] unchanged.
- req0 MREAD; pull reset_n low during WAIT.
  - Required: next cycle state IDLE, no done0, rdata = 0, busy = 0. After release, a re-held req0 is re-granted and completes normally.
- req0 with cmd0 = MNONE held 10 cycles.
  - Required: no gnt0, busy = 0, ram_write = 0 throughout. A simultaneous req1 MREAD is granted immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter and sequencer for a shared single-port RAM with a
// registered (1-cycle latency) read port. One access is in flight at a time.
// When both ports request together, the winner is picked round-robin. The
// block drives the RAM address, write enable and write data, and returns read
// data with a one-cycle done pulse. Accesses with the top address bit set
// fall outside the RAM. They complete with err and cause no RAM activity.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset_n    : synchronous active-low reset
//   req0/req1  : request, held with cmd/addr/wdata stable until that done
//   cmd0/cmd1  : 00 none, 01 read, 10 write, 11 treated as none
//   addr0/1    : word address, bit ADDR_W-1 set = outside RAM
//   wdata0/1   : write data
//   gnt0/gnt1  : one-cycle pulse in the cycle the access is issued to RAM
//   done0/1    : one-cycle completion pulse
//   rdata      : read result, valid with done after a read, held afterwards
//   err        : with done, access was outside RAM
//   busy       : arbiter is not idle
//   ram_addr   : RAM address
//   ram_write  : RAM write enable
//   ram_din    : RAM write data
//   ram_dout   : RAM registered read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q,  last_d;
    logic [1:0]          cmd_q,   cmd_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic valid0;
    logic valid1;
    logic winner;
    logic out_of_range;

    // Only real reads and writes compete; MNONE and the reserved 11 encoding
    // never take part in arbitration.
    assign valid0 = req0 && ((cmd0 == CMD_READ) || (cmd0 == CMD_WRITE));
    assign valid1 = req1 && ((cmd1 == CMD_READ) || (cmd1 == CMD_WRITE));

    assign out_of_range = addr_q[ADDR_W-1];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        winner  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid0 || valid1) begin
                    // On a tie the port that did not win last time goes next,
                    // which gives strict alternation under continuous load.
                    if (valid0 && valid1) begin
                        winner = ~last_q;
                    end else begin
                        winner = valid1;
                    end
                    owner_d = winner;
                    last_d  = winner;
                    cmd_d   = winner ? cmd1   : cmd0;
                    addr_d  = winner ? addr1  : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if ((cmd_q == CMD_READ) && !out_of_range) begin
                    state_d = S_WAIT;
                end else begin
                    // An out-of-range read returns zero instead of stale data.
                    if (cmd_q == CMD_READ) begin
                        rdata_d = '0;
                    end
                    state_d = S_DONE;
                end
            end

            S_WAIT: begin
                // The RAM sampled the address during ISSUE, so its output
                // now holds the addressed word.
                rdata_d = ram_dout;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // All outputs are decoded from registered state; req* never reaches them
    // combinationally.
    assign gnt0      = (state_q == S_ISSUE) && !owner_q;
    assign gnt1      = (state_q == S_ISSUE) &&  owner_q;
    assign done0     = (state_q == S_DONE)  && !owner_q;
    assign done1     = (state_q == S_DONE)  &&  owner_q;
    assign err       = (state_q == S_DONE)  && out_of_range;
    assign busy      = (state_q != S_IDLE);
    assign ram_write = (state_q == S_ISSUE) && (cmd_q == CMD_WRITE) && !out_of_range;
    assign ram_addr  = addr_q[RAM_AW-1:0];
    assign ram_din   = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural 256x16 RAM with a
// registered read port sits behind the DUT. Each access pushes its expected
// completion (port, err, read data) to a queue when it is driven. A monitor
// pops and compares whenever a done pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_RD   = 2'b01;
    localparam logic [1:0] C_WR   = 2'b10;
    localparam logic [1:0] C_RSV  = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        req0, req1;
    logic [1:0]  cmd0, cmd1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err, busy, ram_write;
    logic [15:0] rdata, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    logic [15:0] mem [256];

    typedef struct packed {
        logic        port;
        logic        is_rd;
        logic        err;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   no_wr   = 1'b0;

    mem_arbiter #(.DATA_W(16), .ADDR_W(9), .RAM_AW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, registered read (old data on a same-address write).
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every completion against the oldest expectation.
    always @(negedge clk) begin
        if (done0 || done1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_port", {31'b0, done1}, {31'b0, e.port});
                check("done_both", {31'b0, done0 && done1}, 0);
                check("err", {31'b0, err}, {31'b0, e.err});
                if (e.is_rd) check("rdata", {16'b0, rdata}, {16'b0, e.rd});
            end
        end
        if (ram_write && !(gnt0 || gnt1)) check("write_outside_issue", 1, 0);
        if (no_wr && ram_write) check("write_out_of_range", 1, 0);
    end

    task automatic push_exp(input logic port, input logic [1:0] cmd,
                            input logic [8:0] addr, input logic [15:0] rd);
        exp_t e;
        e.port  = port;
        e.is_rd = (cmd == C_RD);
        e.err   = addr[8];
        e.rd    = rd;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Single-port access with grant/done latency checks (cycle 1 = first
    // cycle after the edge that samples the request in IDLE).
    task automatic access(input logic port, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rd,
                          input int exp_done, input logic exp_wr);
        int gnt_c;
        int done_c;
        gnt_c  = 0;
        done_c = 0;
        wait_idle();
        push_exp(port, cmd, addr, exp_rd);
        if (port) begin
            req1 = 1'b1; cmd1 = cmd; addr1 = addr; wdata1 = wd;
        end else begin
            req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = wd;
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (port ? gnt1 : gnt0) begin
                gnt_c = c;
                check("issue_write", {31'b0, ram_write}, {31'b0, exp_wr});
                check("issue_addr", {24'b0, ram_addr}, {24'b0, addr[7:0]});
                if (exp_wr) check("issue_din", {16'b0, ram_din}, {16'b0, wd});
            end
            if (c == 1) check("gnt_other", {31'b0, port ? gnt0 : gnt1}, 0);
            if (port ? done1 : done0) begin
                done_c = c;
                break;
            end
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
        check("gnt_cycle", gnt_c, 1);
        check("done_cycle", done_c, exp_done);
    endtask

    // Run until every queued completion has been seen.
    task automatic wait_drain(input bit drop_on_done, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (drop_on_done) begin
                if (done0) req0 = 1'b0;
                if (done1) req1 = 1'b0;
            end
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; cmd0 = C_NONE; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; cmd1 = C_NONE; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {gnt0, gnt1, done0, done1, err, busy, ram_write}, 0);
        check("rst_rdata", {16'b0, rdata}, 0);
        check("rst_ram_addr", {24'b0, ram_addr}, 0);
        check("rst_ram_din", {16'b0, ram_din}, 0);
        reset_n = 1'b1;

        // Write then read back through port 0.
        access(1'b0, C_WR, 9'h005, 16'hABCD, 16'h0000, 2, 1'b1);
        access(1'b0, C_RD, 9'h005, 16'h0000, 16'hABCD, 3, 1'b0);

        // Preload words used by the tie test.
        access(1'b0, C_WR, 9'h001, 16'h1111, 16'h0000, 2, 1'b1);
        access(1'b1, C_WR, 9'h002, 16'h2222, 16'h0000, 2, 1'b1);

        // Both ports read straight out of reset: port 0 wins the first tie.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_exp(1'b0, C_RD, 9'h001, 16'h1111);
        push_exp(1'b1, C_RD, 9'h002, 16'h2222);
        req0 = 1'b1; cmd0 = C_RD; addr0 = 9'h001;
        req1 = 1'b1; cmd1 = C_RD; addr1 = 9'h002;
        wait_drain(1'b1, 40);
        req0 = 1'b0; req1 = 1'b0;

        // Both hold write requests: grants alternate 0,1,0.
        wait_idle();
        push_exp(1'b0, C_WR, 9'h001, 16'h0);
        push_exp(1'b1, C_WR, 9'h002, 16'h0);
        push_exp(1'b0, C_WR, 9'h001, 16'h0);
        req0 = 1'b1; cmd0 = C_WR; addr0 = 9'h001; wdata0 = 16'h1111;
        req1 = 1'b1; cmd1 = C_WR; addr1 = 9'h002; wdata1 = 16'h2222;
        wait_drain(1'b0, 60);
        req0 = 1'b0; req1 = 1'b0;

        // Out-of-range write and read on port 1.
        no_wr = 1'b1;
        access(1'b1, C_WR, 9'h105, 16'hDEAD, 16'h0000, 2, 1'b0);
        access(1'b1, C_RD, 9'h105, 16'h0000, 16'h0000, 2, 1'b0);
        no_wr = 1'b0;
        check("mem5_kept", {16'b0, mem[5]}, 32'h0000ABCD);
        access(1'b1, C_RD, 9'h005, 16'h0000, 16'hABCD, 3, 1'b0);

        // Reset during WAIT drops the read with no done.
        wait_idle();
        req0 = 1'b1; cmd0 = C_RD; addr0 = 9'h002;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("in_wait_busy", {31'b0, busy}, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", {31'b0, busy}, 0);
        check("rst_mid_done", {30'b0, done0, done1}, 0);
        check("rst_mid_rdata", {16'b0, rdata}, 0);
        check("rst_mid_write", {31'b0, ram_write}, 0);
        reset_n = 1'b1;
        req0 = 1'b0;
        access(1'b0, C_RD, 9'h002, 16'h0000, 16'h2222, 3, 1'b0);

        // MNONE / reserved command held: never granted.
        req0 = 1'b1; addr0 = 9'h005;
        for (int i = 0; i < 10; i++) begin
            cmd0 = (i < 5) ? C_NONE : C_RSV;
            @(posedge clk); #1;
            check("mnone_idle", {29'b0, gnt0, busy, ram_write}, 0);
        end
        access(1'b1, C_RD, 9'h001, 16'h0000, 16'h1111, 3, 1'b0);
        req0 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
